pc_redirect_ctrl: RTL
=====================

Name: pc_redirect_ctrl

Overview:
Control-side driver of the synchronous program counter's update interface. It drives the counter's en, stall, load_pc and pc_new inputs, and produces the matching pipeline flush signals. It arbitrates EX-stage branches, ID-stage jumps, load-use stalls and syscall halt/resume. It holds a redirect that arrives while halted and applies it on resume, and it keeps saturating statistics counters.

Parameters:
IM_ADDR_BIT, 10, instruction-memory word-address width; the PC advances by 1 per instruction.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_branch_taken  in  1  conditional branch in EX resolved taken
ex_branch_target  in  IM_ADDR_BIT  branch target word address
id_valid  in  1  ID holds a real (non-bubble) instruction
id_is_j  in  1  J or JAL in ID
id_is_jr  in  1  JR or JALR in ID
id_j_target  in  IM_ADDR_BIT  jump target formed from imm26
id_jr_target  in  IM_ADDR_BIT  forwarded rs value (word address)
load_use_hazard  in  1  load-use hazard detected in ID
halt_req  in  1  syscall-halt in EX
resume  in  1  single-cycle resume pulse (debounced go)
en  out  1  PC enable
stall  out  1  PC hold
load_pc  out  1  PC load
pc_new  out  IM_ADDR_BIT  PC load value
flush_if_id  out  1  bubble IF/ID at next edge
flush_id_ex  out  1  bubble ID/EX at next edge
halted  out  1  FSM in HALTED
redirect_cnt  out  CNT_W  taken redirects applied
stall_cnt  out  CNT_W  cycles with stall=1

Behaviour:
- Reset (rst=1 at posedge): state=RUN, pend_valid=0, pend_addr=0, both counters=0. During reset, en, load_pc and stall are don't-care, because the PC itself is reset to 0.
- en, stall, load_pc, pc_new and the flush outputs are combinational from the inputs and registered state, with zero-cycle latency: the PC samples them at the same edge. halted and the counters are registered.
- FSM states:
  - RUN: en=1.
    - Priority 1, ex_branch_taken: load_pc=1, pc_new=ex_branch_target, flush_if_id=1, flush_id_ex=1. Any ID jump and load_use_hazard are ignored, because the younger instructions are squashed.
    - Priority 2, id_valid and id_is_j and not load_use_hazard: load_pc=1, pc_new=id_j_target, flush_if_id=1.
    - Priority 3, id_valid and id_is_jr and not load_use_hazard: load_pc=1, pc_new=id_jr_target, flush_if_id=1.
    - Priority 4, load_use_hazard: stall=1, load_pc=0, flush_id_ex=1. A jump in ID is retried after the hazard clears.
    - Otherwise load_pc=0, stall=0, and the PC increments.
    - On halt_req: next state=HALTED. If ex_branch_taken is also 1, the redirect still applies this cycle; halt_req does not gate it.
  - HALTED: en=0, stall=1, load_pc=0, flushes=0.
    - An ex_branch_taken seen here sets pend_valid=1 and pend_addr=ex_branch_target.
    - If several arrive, the last one wins.
    - On resume: next state=RESUME.
  - RESUME (one cycle): en=1.
    - If pend_valid: load_pc=1, pc_new=pend_addr, flush_if_id=1, flush_id_ex=1, and pend_valid clears.
    - Otherwise follow the RUN rules.
    - Next state=RUN. If halt_req is 1 in this cycle, next state=HALTED instead.
- resume in RUN is ignored. halt_req in HALTED is ignored. A resume coinciding with ex_branch_taken in HALTED captures the branch first, then applies it in RESUME.
- pc_new carries a valid address only when load_pc=1. Otherwise it is 0.
- Counters:
  - redirect_cnt increments on every cycle with en=1 and load_pc=1.
  - stall_cnt increments on every cycle with stall=1, including HALTED cycles.
  - Both saturate at all-ones and do not wrap.
- Reset mid-operation (any state, pending redirect held): everything returns to the reset values at that edge, and the pending redirect is discarded.
- Widths: all addresses are IM_ADDR_BIT bits with no truncation or extension inside the block.

Test Plan:
1. Reset, then 4 idle cycles with no hazards -> en=1, load_pc=0, stall=0, counters 0. A PC model steps 0,1,2,3.
2. ex_branch_taken=1 with target 0x040, in the same cycle as id_is_j with target 0x100 and load_use_hazard=1 -> load_pc=1, pc_new=0x040, flush_if_id=1, flush_id_ex=1, stall=0, redirect_cnt=1.
3. id_is_jr with target 0x123 while load_use_hazard=1 for 1 cycle, then 0 -> cycle 1: stall=1, load_pc=0, flush_id_ex=1. Cycle 2: load_pc=1, pc_new=0x123, flush_if_id=1. stall_cnt=1.
4. halt_req, then branches to 0x010 and 0x020 while HALTED, then resume -> halted=1 for the HALTED cycles. In the RESUME cycle: load_pc=1, pc_new=0x020, then RUN with halted=0.
5. rst=1 while HALTED with a redirect pending, then resume -> state=RUN, no load_pc from the discarded pend_addr, counters 0.
6. Force load_use_hazard=1 for 70000 cycles with CNT_W=16 -> stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: drives the program counter's update interface and
// the matching pipeline flushes. It arbitrates EX branches, ID jumps,
// load-use stalls and syscall halt/resume, and keeps saturating statistics.
module pc_redirect_ctrl #(
  parameter int unsigned IM_ADDR_BIT = 10,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_branch_taken,
  input  logic [IM_ADDR_BIT-1:0] ex_branch_target,
  input  logic                   id_valid,
  input  logic                   id_is_j,
  input  logic                   id_is_jr,
  input  logic [IM_ADDR_BIT-1:0] id_j_target,
  input  logic [IM_ADDR_BIT-1:0] id_jr_target,
  input  logic                   load_use_hazard,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic                   en,
  output logic                   stall,
  output logic                   load_pc,
  output logic [IM_ADDR_BIT-1:0] pc_new,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   halted,
  output logic [CNT_W-1:0]       redirect_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StResume = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e                 state_q, state_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [IM_ADDR_BIT-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]       redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic                   use_run_rules;

  // Next-state and zero-latency PC control outputs.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    en           = 1'b0;
    stall        = 1'b0;
    load_pc      = 1'b0;
    pc_new       = '0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    use_run_rules = 1'b0;

    unique case (state_q)
      StRun: begin
        use_run_rules = 1'b1;
        if (halt_req) state_d = StHalted;
      end
      StHalted: begin
        stall = 1'b1;
        // Last branch seen while halted wins; captured even on the resume cycle.
        if (ex_branch_taken) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = ex_branch_target;
        end
        if (resume) state_d = StResume;
      end
      StResume: begin
        if (pend_valid_q) begin
          en           = 1'b1;
          load_pc      = 1'b1;
          pc_new       = pend_addr_q;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          pend_valid_d = 1'b0;
        end else begin
          use_run_rules = 1'b1;
        end
        state_d = halt_req ? StHalted : StRun;
      end
      default: state_d = StRun;
    endcase

    if (use_run_rules) begin
      en = 1'b1;
      if (ex_branch_taken) begin
        // Younger instructions are squashed, so ID jumps and hazards are ignored.
        load_pc     = 1'b1;
        pc_new      = ex_branch_target;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (id_valid && id_is_j && !load_use_hazard) begin
        load_pc     = 1'b1;
        pc_new      = id_j_target;
        flush_if_id = 1'b1;
      end else if (id_valid && id_is_jr && !load_use_hazard) begin
        load_pc     = 1'b1;
        pc_new      = id_jr_target;
        flush_if_id = 1'b1;
      end else if (load_use_hazard) begin
        // A jump held in ID is retried once the hazard clears.
        stall       = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  // Saturating statistics counters.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (en && load_pc && (redirect_cnt_q != CntMax)) redirect_cnt_d = redirect_cnt_q + 1'b1;
    if (stall && (stall_cnt_q != CntMax))            stall_cnt_d    = stall_cnt_q + 1'b1;
  end

  // State register with synchronous reset; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_addr_q    <= pend_addr_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign halted       = (state_q == StHalted);
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
